// File: rtl/mathgame_pkg.sv
// mathgame_pkg: shared state enum, BCD digit type and constants for the math game
package mathgame_pkg;
   typedef enum logic [1:0] {IDLE, PLAY, OVER} rs_state_t;
   typedef logic [3:0] bcd_t;
   localparam bcd_t BCD_NINE = 4'd9;
endpackage

// File: rtl/bcd2_sat_add.sv
// bcd2_sat_add: two-digit BCD add of a small increment, saturating at a BCD ceiling
module bcd2_sat_add
   import mathgame_pkg::*;
(
   input  logic [3:0] a_tens,
   input  logic [3:0] a_ones,
   input  logic [1:0] inc,
   input  logic [3:0] max_tens,
   input  logic [3:0] max_ones,
   output logic [3:0] sum_tens,
   output logic [3:0] sum_ones
);
   logic [4:0] ones_raw;
   logic [4:0] tens_raw;
   logic [3:0] ones_wrap;
   logic       carry;
   logic       over;
   // tens gets a fifth bit so 99+1 is seen as above any legal ceiling
   always_comb begin
      ones_raw  = {1'b0, a_ones} + {3'b0, inc};
      carry     = ones_raw > {1'b0, BCD_NINE};
      ones_wrap = carry ? 4'(ones_raw - 5'd10) : ones_raw[3:0];
      tens_raw  = {1'b0, a_tens} + {4'b0, carry};
      over      = {tens_raw, ones_wrap} > {1'b0, max_tens, max_ones};
      sum_tens  = over ? max_tens : tens_raw[3:0];
      sum_ones  = over ? max_ones : ones_wrap;
   end
endmodule

// File: rtl/round_scorekeeper.sv
// round_scorekeeper: game FSM, BCD score with streak tracking and session best; ROUND_SCORE_STREAK_BONUS_EN enables bonus hits
module round_scorekeeper
   import mathgame_pkg::*;
#(
   parameter int MAX_SCORE    = 99,
   parameter int BONUS_PERIOD = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_start,
   input  logic       round_valid,
   input  logic       round_hit,
   input  logic       time_up,
   output logic [3:0] score_ones,
   output logic [3:0] score_tens,
   output logic [3:0] best_ones,
   output logic [3:0] best_tens,
   output logic [3:0] streak,
   output logic       playing,
   output logic       game_over,
   output logic       new_best
);
   localparam bcd_t MAX_TENS = bcd_t'(MAX_SCORE / 10);
   localparam bcd_t MAX_ONES = bcd_t'(MAX_SCORE % 10);
   if (MAX_SCORE < 1 || MAX_SCORE > 99 || BONUS_PERIOD < 1 || BONUS_PERIOD > 31) begin : g_bad_param
      $error("round_scorekeeper: illegal MAX_SCORE or BONUS_PERIOD");
   end
   rs_state_t  state_q, state_d;
   bcd_t       sc_tens_q, sc_tens_d, sc_ones_q, sc_ones_d;
   bcd_t       best_tens_q, best_tens_d, best_ones_q, best_ones_d;
   logic [3:0] streak_q, streak_d, streak_inc;
   logic       playing_q, playing_d, game_over_q, game_over_d, new_best_q, new_best_d;
   logic [1:0] inc;
   bcd_t       add_tens, add_ones;
   // streak after a hit, and whether that hit earns the bonus increment
   always_comb begin
      streak_inc = (streak_q == 4'd15) ? 4'd15 : streak_q + 4'd1;
`ifdef ROUND_SCORE_STREAK_BONUS_EN
      inc = (({1'b0, streak_inc} % 5'(BONUS_PERIOD)) == 5'd0) ? 2'd2 : 2'd1;
`else
      inc = 2'd1;
`endif
   end
   bcd2_sat_add u_add (
      .a_tens   (sc_tens_q),
      .a_ones   (sc_ones_q),
      .inc      (inc),
      .max_tens (MAX_TENS),
      .max_ones (MAX_ONES),
      .sum_tens (add_tens),
      .sum_ones (add_ones)
   );
   // next state: the round is scored before time_up so the best compare sees the final score
   always_comb begin
      state_d     = state_q;
      sc_tens_d   = sc_tens_q;
      sc_ones_d   = sc_ones_q;
      streak_d    = streak_q;
      best_tens_d = best_tens_q;
      best_ones_d = best_ones_q;
      new_best_d  = 1'b0;
      if (state_q == PLAY) begin
         if (round_valid) begin
            streak_d  = round_hit ? streak_inc : 4'd0;
            sc_tens_d = round_hit ? add_tens : sc_tens_q;
            sc_ones_d = round_hit ? add_ones : sc_ones_q;
         end
         if (time_up) begin
            state_d = OVER;
            if ({sc_tens_d, sc_ones_d} > {best_tens_q, best_ones_q}) begin
               best_tens_d = sc_tens_d;
               best_ones_d = sc_ones_d;
               new_best_d  = 1'b1;
            end
         end
      end else if (game_start) begin
         state_d   = PLAY;
         sc_tens_d = '0;
         sc_ones_d = '0;
         streak_d  = '0;
      end
      playing_d   = state_d == PLAY;
      game_over_d = state_d == OVER;
   end
   // state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sc_tens_q   <= '0;
         sc_ones_q   <= '0;
         streak_q    <= '0;
         best_tens_q <= '0;
         best_ones_q <= '0;
         playing_q   <= 1'b0;
         game_over_q <= 1'b0;
         new_best_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sc_tens_q   <= sc_tens_d;
         sc_ones_q   <= sc_ones_d;
         streak_q    <= streak_d;
         best_tens_q <= best_tens_d;
         best_ones_q <= best_ones_d;
         playing_q   <= playing_d;
         game_over_q <= game_over_d;
         new_best_q  <= new_best_d;
      end
   end
   assign score_tens = sc_tens_q;
   assign score_ones = sc_ones_q;
   assign best_tens  = best_tens_q;
   assign best_ones  = best_ones_q;
   assign streak     = streak_q;
   assign playing    = playing_q;
   assign game_over  = game_over_q;
   assign new_best   = new_best_q;
endmodule

// File: tb/tb_round_scorekeeper.sv
// tb_round_scorekeeper: directed self-checking bench for round_scorekeeper
module tb_round_scorekeeper;
   logic       clk = 1'b0;
   logic       rst, game_start, round_valid, round_hit, time_up;
   logic [3:0] score_ones, score_tens, best_ones, best_tens, streak;
   logic       playing, game_over, new_best;
   int         checks = 0;
   int         failures = 0;
`ifdef ROUND_SCORE_STREAK_BONUS_EN
   localparam bit BON = 1'b1;
`else
   localparam bit BON = 1'b0;
`endif
   always #5 clk = ~clk;
   round_scorekeeper dut (
      .clk         (clk),
      .rst         (rst),
      .game_start  (game_start),
      .round_valid (round_valid),
      .round_hit   (round_hit),
      .time_up     (time_up),
      .score_ones  (score_ones),
      .score_tens  (score_tens),
      .best_ones   (best_ones),
      .best_tens   (best_tens),
      .streak      (streak),
      .playing     (playing),
      .game_over   (game_over),
      .new_best    (new_best)
   );
   function automatic logic [7:0] bcd(input int d);
      return {4'(d / 10), 4'(d % 10)};
   endfunction
   task automatic act(input logic s, input logic v, input logic h, input logic t);
      game_start  = s;
      round_valid = v;
      round_hit   = h;
      time_up     = t;
      @(posedge clk);
      #1;
      game_start  = 1'b0;
      round_valid = 1'b0;
      round_hit   = 1'b0;
      time_up     = 1'b0;
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic expect_all(input string tag, input int sc, input int st, input int be, input logic [2:0] stat);
      chk({tag, " score"}, {score_tens, score_ones}, bcd(sc));
      chk({tag, " streak"}, {4'd0, streak}, 8'(st));
      chk({tag, " best"}, {best_tens, best_ones}, bcd(be));
      chk({tag, " status"}, {5'd0, playing, game_over, new_best}, {5'd0, stat});
   endtask
   task automatic hit_model(input string tag, inout int sc, inout int st, input int be);
      int add;
      act(1'b0, 1'b1, 1'b1, 1'b0);
      st  = (st == 15) ? 15 : st + 1;
      add = (BON && (st % 3 == 0)) ? 2 : 1;
      sc  = (sc + add > 99) ? 99 : sc + add;
      expect_all(tag, sc, st, be, 3'b100);
   endtask
   task automatic miss_model(input string tag, input int sc, inout int st, input int be);
      act(1'b0, 1'b1, 1'b0, 1'b0);
      st = 0;
      expect_all(tag, sc, st, be, 3'b100);
   endtask
   initial begin
      int hit5[5];
      int sc_t[10];
      int st_t[10];
      int sc2[6];
      int st2[6];
      int top, msc, ms;
      hit5 = '{1, 2, BON ? 4 : 3, BON ? 5 : 4, BON ? 6 : 5};
      sc_t = '{1, 2, 2, 3, 4, 4, 5, 6, 6, 7};
      st_t = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1};
      sc2  = '{1, 2, 2, 3, 3, 4};
      st2  = '{1, 2, 0, 1, 0, 1};
      rst = 1'b1;
      game_start = 1'b0;
      round_valid = 1'b0;
      round_hit = 1'b0;
      time_up = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      expect_all("reset", 0, 0, 0, 3'b000);
      act(1'b1, 1'b0, 1'b0, 1'b0);
      expect_all("start", 0, 0, 0, 3'b100);
      for (int i = 0; i < 5; i++) begin
         act(1'b0, 1'b1, 1'b1, 1'b0);
         expect_all($sformatf("hit%0d", i), hit5[i], i + 1, 0, 3'b100);
      end
      top = hit5[4];
      act(1'b0, 1'b1, 1'b0, 1'b0);
      expect_all("miss", top, 0, 0, 3'b100);
      act(1'b1, 1'b0, 1'b0, 1'b0);
      expect_all("start_in_play", top, 0, 0, 3'b100);
      act(1'b0, 1'b0, 1'b0, 1'b1);
      expect_all("time_up", top, 0, top, 3'b011);
      act(1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("over_hold", top, 0, top, 3'b010);
      act(1'b0, 1'b1, 1'b1, 1'b0);
      expect_all("rv_in_over", top, 0, top, 3'b010);
      act(1'b1, 1'b0, 1'b0, 1'b0);
      expect_all("restart", 0, 0, top, 3'b100);
      msc = 0;
      ms = 0;
      while (msc < 95) hit_model("climb", msc, ms, top);
      if (msc == 95) begin
         miss_model("align_miss", msc, ms, top);
         hit_model("align_hit", msc, ms, top);
      end
      miss_model("pre_sat_miss", msc, ms, top);
      hit_model("to97", msc, ms, top);
      hit_model("to98", msc, ms, top);
      hit_model("sat_step", msc, ms, top);
      chk("sat_value", {score_tens, score_ones}, 8'h99);
      hit_model("sat_hold", msc, ms, top);
      chk("sat_hold_value", {score_tens, score_ones}, 8'h99);
      chk("digits_legal", {6'd0, score_tens <= 4'd9, score_ones <= 4'd9}, 8'd3);
      act(1'b0, 1'b0, 1'b0, 1'b1);
      expect_all("sat_over", 99, ms, 99, 3'b011);
      act(1'b1, 1'b0, 1'b0, 1'b0);
      expect_all("game3", 0, 0, 99, 3'b100);
      for (int i = 0; i < 10; i++) begin
         act(1'b0, 1'b1, st_t[i] != 0, 1'b0);
         expect_all($sformatf("g3_step%0d", i), sc_t[i], st_t[i], 99, 3'b100);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_all("mid_reset", 0, 0, 0, 3'b000);
      act(1'b0, 1'b1, 1'b1, 1'b0);
      expect_all("rv_idle", 0, 0, 0, 3'b000);
      act(1'b1, 1'b0, 1'b0, 1'b0);
      expect_all("game4", 0, 0, 0, 3'b100);
      for (int i = 0; i < 4; i++) begin
         act(1'b0, 1'b1, st_t[i] != 0, 1'b0);
         expect_all($sformatf("g4_step%0d", i), sc_t[i], st_t[i], 0, 3'b100);
      end
      act(1'b0, 1'b0, 1'b0, 1'b1);
      expect_all("g4_over", 3, 1, 3, 3'b011);
      act(1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("g4_hold", 3, 1, 3, 3'b010);
      act(1'b1, 1'b0, 1'b0, 1'b0);
      expect_all("game5", 0, 0, 3, 3'b100);
      for (int i = 0; i < 6; i++) begin
         act(1'b0, 1'b1, st2[i] != 0, 1'b0);
         expect_all($sformatf("g5_step%0d", i), sc2[i], st2[i], 3, 3'b100);
      end
      act(1'b0, 1'b1, 1'b1, 1'b1);
      expect_all("hit_and_time_up", 5, 2, 5, 3'b011);
      act(1'b0, 1'b0, 1'b0, 1'b0);
      expect_all("new_best_drop", 5, 2, 5, 3'b010);
      act(1'b1, 1'b0, 1'b0, 1'b0);
      expect_all("game6", 0, 0, 5, 3'b100);
      for (int i = 0; i < 6; i++) begin
         act(1'b0, 1'b1, st2[i] != 0, 1'b0);
         expect_all($sformatf("g6_step%0d", i), sc2[i], st2[i], 5, 3'b100);
      end
      act(1'b0, 1'b1, 1'b1, 1'b1);
      expect_all("equal_no_best", 5, 2, 5, 3'b010);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/round_scorekeeper.md
# round_scorekeeper

Round-scoring stage for the math game. It sits directly downstream of the sum-equals-15 checker and the two-digit countdown timer, and consumes their per-round hit/miss result and the time-up condition. It runs the game-session state machine, keeps a two-digit BCD score with hit-streak tracking, and retains the session best score across games. Its outputs feed two seven-segment decoder pairs and the game-status LEDs.

## Interface
Parameters:
- `MAX_SCORE`, default 99: saturation ceiling for the score, in decimal. Legal range is 1–99.
- `BONUS_PERIOD`, default 3: a hit is a bonus hit when the streak after that hit is a multiple of this value.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `game_start` in 1: one-cycle pulse, already button-shaped. Starts a game.
- `round_valid` in 1: one-cycle pulse. The player committed a guess this cycle.
- `round_hit` in 1: qualified by `round_valid`. 1 means sum==15, 0 means miss.
- `time_up` in 1: level. The countdown has reached 00.
- `score_ones`, `score_tens` out 4 each: current score in BCD.
- `best_ones`, `best_tens` out 4 each: best score in BCD.
- `streak` out 4: count of consecutive hits, saturating at 15.
- `playing` out 1: high in state PLAY.
- `game_over` out 1: high in state OVER.
- `new_best` out 1: one-cycle pulse when the best score is replaced.

## Operation
- The FSM has three states: IDLE, PLAY, OVER.
- IDLE to PLAY happens on `game_start`. Score and streak clear to 0 on the same edge.
- PLAY to OVER happens when `time_up` is 1.
- OVER to PLAY happens on `game_start`. Score and streak clear; best is kept.
- `game_start` is ignored while in PLAY.
- `round_valid` is ignored outside PLAY.
- A hit while in PLAY does the following:
  - `streak` increments, saturating at 15.
  - The score increments by 1.
  - With the bonus feature enabled, a bonus hit adds 2 instead of 1.
- A miss while in PLAY sets `streak` to 0 and leaves the score unchanged.
- Score arithmetic:
  - Two-digit BCD add of 1 or 2, with the ones digit carrying into the tens digit.
  - The result saturates at `MAX_SCORE`. For example, 98+2 gives 99, and 99+1 gives 99.
  - Digits never hold a value of 10–15.
- Best-score update:
  - Evaluated on the PLAY-to-OVER edge.
  - If the final score (after any same-cycle round update) is strictly greater than best, best takes that score and `new_best` is 1 for the first OVER cycle only.
  - An equal score does not replace best.
- `round_valid` and `time_up` in the same PLAY cycle: the round is scored first, then the FSM goes to OVER. The best comparison uses the updated score.
- `rst` at any time: the FSM goes to IDLE, and every output is 0, including best. This also applies mid-game.

## Timing
- All outputs are registered.
- Score, streak and state update on the edge that samples `round_valid`/`time_up`/`game_start`, and are visible in the next cycle. Latency is 1 cycle.
- `new_best` is 1 for exactly the first cycle in which `game_over` is 1.
- Back-to-back `round_valid` on consecutive cycles are each scored. There is no throttling or handshake back-pressure.
- Reset values:
  - `score_ones`, `score_tens`, `best_ones`, `best_tens`, `streak` = 0.
  - `playing` = 0, `game_over` = 0, `new_best` = 0.
  - State = IDLE.

## Configuration
- `ROUND_SCORE_STREAK_BONUS_EN` defined: bonus hits add 2 points.
- `ROUND_SCORE_STREAK_BONUS_EN` undefined: every hit adds 1. The `BONUS_PERIOD` parameter is unused, but `streak` is still tracked and output.

## Structure
- Shared package `mathgame_pkg` contains:
  - the state enum `rs_state_t` (IDLE, PLAY, OVER);
  - BCD digit typedef `bcd_t` [3:0];
  - constant `BCD_NINE`.
- Sub-module `bcd2_sat_add`: combinational. It takes a two-digit BCD value, an increment of 1 or 2, and a two-digit BCD ceiling. It returns the saturated two-digit BCD sum.
- The FSM, streak counter and best register live in `round_scorekeeper`.

## Test plan
- Reset then `game_start`: `playing`=1 next cycle, score=00, best=00.
- Bonus enabled, five hits:
  - score sequence 01, 02, 04, 05, 06;
  - streak sequence 1, 2, 3, 4, 5.
- Hit, hit, miss, hit: score reaches 03, streak=1, then 04 (bonus enabled: 01, 02, 02, 03).
- Preload score 98 via hits, then a bonus hit: score=99. A further hit: score stays 99 and digits stay legal.
- `round_valid`+`round_hit` together with `time_up` at score 04, best 03:
  - score=05;
  - `game_over`=1;
  - best=05;
  - `new_best` pulses for 1 cycle.
  - Replay ending with score 05: `new_best` stays 0.
- `rst` asserted mid-PLAY at score 07: next cycle all outputs are 0 and state is IDLE. `round_valid` in IDLE leaves the score at 00.
